pspin_hostmem_dma_rd_arb: RTL

- N-port AXI4 read arbiter placed in front of the single-transaction host memory DMA read datapath.
- Accepts AR requests from up to PORTS PsPIN masters and grants one at a time, round-robin.
- Forwards the granted AR to the datapath and routes the returning R burst back to the granted port.
- Holds the grant until the burst's RLAST handshake completes, because the datapath has only one transaction in flight.

---
 rtl/pspin_hostmem_dma_rd_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pspin_hostmem_dma_rd_arb.sv
// Round-robin AXI4 read arbiter feeding the single-outstanding host memory DMA read datapath.
// Optional QoS-first selection is enabled with the PSPIN_HOSTMEM_RD_ARB_QOS_EN macro.
module pspin_hostmem_dma_rd_arb #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*ID_WIDTH-1:0]     s_axi_arid,
  input  logic [PORTS*ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [PORTS*8-1:0]            s_axi_arlen,
  input  logic [PORTS*3-1:0]            s_axi_arsize,
  input  logic [PORTS*2-1:0]            s_axi_arburst,
  input  logic [PORTS*4-1:0]            s_axi_arqos,
  input  logic [PORTS-1:0]              s_axi_arvalid,
  output logic [PORTS-1:0]              s_axi_arready,
  output logic [PORTS*ID_WIDTH-1:0]     s_axi_rid,
  output logic [PORTS*DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [PORTS*2-1:0]            s_axi_rresp,
  output logic [PORTS-1:0]              s_axi_rlast,
  output logic [PORTS-1:0]              s_axi_rvalid,
  input  logic [PORTS-1:0]              s_axi_rready,
  output logic [ID_WIDTH-1:0]           m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [ID_WIDTH-1:0]           m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [$clog2(PORTS)-1:0]      grant_idx,
  output logic                          busy,
  output logic                          proto_err
);

  localparam int IDX_W = $clog2(PORTS);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(PORTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AR_FWD = 2'd1,
    R_DATA = 2'd2
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      grant_q;
  logic [8:0]            beat_cnt_q;
  logic [ID_WIDTH-1:0]   arid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic [1:0]            arburst_q;
  logic                  arvalid_q;
  logic                  proto_err_q;

  logic [PORTS-1:0]      eligible_s;
  logic                  win_found_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [PORTS-1:0]      win_onehot_s;

`ifdef PSPIN_HOSTMEM_RD_ARB_QOS_EN
  logic [3:0] max_qos_s;

  // Restrict the candidate set to requesters carrying the highest ARQOS.
  always_comb begin
    max_qos_s  = 4'd0;
    eligible_s = {PORTS{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      if (s_axi_arvalid[i] && (s_axi_arqos[i*4 +: 4] > max_qos_s)) begin
        max_qos_s = s_axi_arqos[i*4 +: 4];
      end else begin
        max_qos_s = max_qos_s;
      end
    end
    for (int i = 0; i < PORTS; i++) begin
      eligible_s[i] = s_axi_arvalid[i] && (s_axi_arqos[i*4 +: 4] == max_qos_s);
    end
  end
`else
  logic unused_qos_s;
  assign unused_qos_s = ^s_axi_arqos;
  assign eligible_s   = s_axi_arvalid;
`endif

  // First eligible port when scanning from rr_ptr upwards with wrap-around.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int k = 0; k < PORTS; k++) begin
      cand = (int'(rr_ptr_q) + k) % PORTS;
      if (!win_found_s && eligible_s[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_onehot_s  = {{(PORTS-1){1'b0}}, 1'b1} << win_idx_s;
  assign s_axi_arready = (state_q == IDLE && win_found_s && !rst) ? win_onehot_s : {PORTS{1'b0}};

  // R channel is a straight wire to the granted port while a burst is open.
  always_comb begin
    s_axi_rid    = {(PORTS*ID_WIDTH){1'b0}};
    s_axi_rdata  = {(PORTS*DATA_WIDTH){1'b0}};
    s_axi_rresp  = {(PORTS*2){1'b0}};
    s_axi_rlast  = {PORTS{1'b0}};
    s_axi_rvalid = {PORTS{1'b0}};
    m_axi_rready = 1'b0;
    if (state_q == R_DATA) begin
      s_axi_rid[grant_q*ID_WIDTH +: ID_WIDTH]       = m_axi_rid;
      s_axi_rdata[grant_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
      s_axi_rresp[grant_q*2 +: 2]                   = m_axi_rresp;
      s_axi_rlast[grant_q]                          = m_axi_rlast;
      s_axi_rvalid[grant_q]                         = m_axi_rvalid;
      m_axi_rready                                  = s_axi_rready[grant_q];
    end else begin
      m_axi_rready = 1'b0;
    end
  end

  // Grant FSM: the grant is held until the RLAST handshake since the datapath has one transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IDX_W{1'b0}};
      grant_q     <= {IDX_W{1'b0}};
      beat_cnt_q  <= 9'd0;
      arid_q      <= {ID_WIDTH{1'b0}};
      araddr_q    <= {ADDR_WIDTH{1'b0}};
      arlen_q     <= 8'd0;
      arsize_q    <= 3'd0;
      arburst_q   <= 2'd0;
      arvalid_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found_s) begin
            arid_q     <= s_axi_arid[win_idx_s*ID_WIDTH +: ID_WIDTH];
            araddr_q   <= s_axi_araddr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            arlen_q    <= s_axi_arlen[win_idx_s*8 +: 8];
            arsize_q   <= s_axi_arsize[win_idx_s*3 +: 3];
            arburst_q  <= s_axi_arburst[win_idx_s*2 +: 2];
            grant_q    <= win_idx_s;
            beat_cnt_q <= 9'd0;
            arvalid_q  <= 1'b1;
            state_q    <= AR_FWD;
          end
        end
        AR_FWD: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            // Early RLAST or missing RLAST on the final beat; the burst still ends on RLAST.
            if ((m_axi_rlast && (beat_cnt_q != {1'b0, arlen_q})) ||
                (!m_axi_rlast && (beat_cnt_q == {1'b0, arlen_q}))) begin
              proto_err_q <= 1'b1;
            end
            if (m_axi_rlast) begin
              state_q  <= IDLE;
              rr_ptr_q <= (grant_q == LAST_PORT) ? {IDX_W{1'b0}} : grant_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;
  assign m_axi_arvalid = arvalid_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q != IDLE);
  assign proto_err     = proto_err_q;

endmodule
